// File: rtl/cache_responder.sv
// Direct-mapped, write-back, write-allocate data cache answering CPU requests.
// Hits complete combinationally; misses run write-back/allocate against a block-wide memory port.
module cache_responder #(
   parameter int NUM_LINES      = 4,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         read_write,
   input  logic                         if_lb,
   input  logic [9:0]                   address,
   input  logic [31:0]                  write_data,
   output logic                         hit_miss,
   output logic [31:0]                  Read_Data,
   output logic                         mem_request,
   output logic                         mem_read_write,
   output logic [9:0]                   mem_address,
   output logic [32*WORDS_PER_LINE-1:0] mem_write_data,
   input  logic [32*WORDS_PER_LINE-1:0] mem_read_data,
   input  logic                         mem_ready
);

   localparam int IDX_W   = 2;
   localparam int TAG_W   = 4;
   localparam int BLOCK_W = 32 * WORDS_PER_LINE;

   typedef enum logic [1:0] {
      COMPARE    = 2'd0,
      WRITE_BACK = 2'd1,
      ALLOCATE   = 2'd2
   } state_t;

   state_t               state_r;
   logic [NUM_LINES-1:0] valid_r;
   logic [NUM_LINES-1:0] dirty_r;
   logic [TAG_W-1:0]     tag_r  [NUM_LINES];
   logic [BLOCK_W-1:0]   data_r [NUM_LINES];
   logic [TAG_W-1:0]     miss_tag_r;
   logic [IDX_W-1:0]     miss_idx_r;
   logic                 mem_request_r;
   logic                 mem_read_write_r;
   logic [9:0]           mem_address_r;
   logic [BLOCK_W-1:0]   mem_write_data_r;

   logic [TAG_W-1:0]     req_tag_s;
   logic [IDX_W-1:0]     req_idx_s;
   logic [1:0]           req_word_s;
   logic [1:0]           req_byte_s;
   logic                 hit_s;
   logic                 victim_dirty_s;
   logic                 write_hit_s;
   logic                 fill_s;
   logic [31:0]          hit_word_s;
   logic [31:0]          read_data_s;

   function automatic logic [31:0] select_word(input logic [BLOCK_W-1:0] block,
                                               input logic [1:0] word_sel);
      logic [31:0] w;
      case (word_sel)
         2'd0:    w = block[31:0];
         2'd1:    w = block[63:32];
         2'd2:    w = block[95:64];
         2'd3:    w = block[127:96];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   // Little-endian byte pick, sign-extended to a full word.
   function automatic logic [31:0] load_byte(input logic [31:0] word,
                                             input logic [1:0] byte_sel);
      logic [7:0] b;
      case (byte_sel)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      return {{24{b[7]}}, b};
   endfunction

   // Request decode and hit detection.
   always_comb begin
      req_tag_s      = address[9:6];
      req_idx_s      = address[5:4];
      req_word_s     = address[3:2];
      req_byte_s     = address[1:0];
      hit_s          = (state_r == COMPARE) && valid_r[req_idx_s]
                       && (tag_r[req_idx_s] == req_tag_s);
      victim_dirty_s = valid_r[req_idx_s] && dirty_r[req_idx_s];
      write_hit_s    = hit_s && read_write;
      fill_s         = (state_r == ALLOCATE) && mem_ready;
   end

   // Load result mux; zero whenever no read completes this cycle.
   always_comb begin
      hit_word_s  = select_word(data_r[req_idx_s], req_word_s);
      read_data_s = 32'd0;
      if (hit_s && !read_write) begin
         if (if_lb) begin
            read_data_s = load_byte(hit_word_s, req_byte_s);
         end else begin
            read_data_s = hit_word_s;
         end
      end else begin
         read_data_s = 32'd0;
      end
   end

   // Data and tag arrays; a reset edge suppresses any pending fill or store.
   always_ff @(posedge clock) begin
      if (reset_n && fill_s) begin
         data_r[miss_idx_r] <= mem_read_data;
         tag_r[miss_idx_r]  <= miss_tag_r;
      end else if (reset_n && write_hit_s) begin
         data_r[req_idx_s][{req_word_s, 5'd0} +: 32] <= write_data;
      end
   end

   // Miss-handling FSM, line status bits and registered memory port.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r          <= COMPARE;
         valid_r          <= {NUM_LINES{1'b0}};
         dirty_r          <= {NUM_LINES{1'b0}};
         miss_tag_r       <= {TAG_W{1'b0}};
         miss_idx_r       <= {IDX_W{1'b0}};
         mem_request_r    <= 1'b0;
         mem_read_write_r <= 1'b0;
         mem_address_r    <= 10'd0;
         mem_write_data_r <= {BLOCK_W{1'b0}};
      end else begin
         case (state_r)
            COMPARE: begin
               if (hit_s) begin
                  if (read_write) begin
                     dirty_r[req_idx_s] <= 1'b1;
                  end
               end else begin
                  miss_tag_r    <= req_tag_s;
                  miss_idx_r    <= req_idx_s;
                  mem_request_r <= 1'b1;
                  if (victim_dirty_s) begin
                     state_r          <= WRITE_BACK;
                     mem_read_write_r <= 1'b1;
                     mem_address_r    <= {tag_r[req_idx_s], req_idx_s, 4'd0};
                     mem_write_data_r <= data_r[req_idx_s];
                  end else begin
                     state_r          <= ALLOCATE;
                     mem_read_write_r <= 1'b0;
                     mem_address_r    <= {req_tag_s, req_idx_s, 4'd0};
                     mem_write_data_r <= {BLOCK_W{1'b0}};
                  end
               end
            end
            WRITE_BACK: begin
               if (mem_ready) begin
                  state_r          <= ALLOCATE;
                  mem_read_write_r <= 1'b0;
                  mem_address_r    <= {miss_tag_r, miss_idx_r, 4'd0};
                  mem_write_data_r <= {BLOCK_W{1'b0}};
               end
            end
            ALLOCATE: begin
               if (mem_ready) begin
                  state_r             <= COMPARE;
                  valid_r[miss_idx_r] <= 1'b1;
                  dirty_r[miss_idx_r] <= 1'b0;
                  mem_request_r       <= 1'b0;
                  mem_read_write_r    <= 1'b0;
                  mem_address_r       <= 10'd0;
                  mem_write_data_r    <= {BLOCK_W{1'b0}};
               end
            end
            default: begin
               state_r          <= COMPARE;
               mem_request_r    <= 1'b0;
               mem_read_write_r <= 1'b0;
               mem_address_r    <= 10'd0;
               mem_write_data_r <= {BLOCK_W{1'b0}};
            end
         endcase
      end
   end

   assign hit_miss       = hit_s;
   assign Read_Data      = read_data_s;
   assign mem_request    = mem_request_r;
   assign mem_read_write = mem_read_write_r;
   assign mem_address    = mem_address_r;
   assign mem_write_data = mem_write_data_r;

endmodule

// File: doc/cache_responder.md
# cache_responder

Direct-mapped, write-back, write-allocate data cache. It is the responder side of the CPU request interface: `hit_miss` / `read_write` / `if_lb` / `address` / `write_data` / `Read_Data`. It sits between the CPU request driver and main memory, answers hits in zero cycles, and runs a write-back/allocate sequence against a 4-word-wide memory port on a miss.

## Interface
- `NUM_LINES`, default 4: cache lines. Only 4 is supported; it sets the index width to 2.
- `WORDS_PER_LINE`, default 4: 32-bit words per line. Only 4 is supported; the block is 128 bits.
- `clock`  in  1  system clock; everything updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `read_write`  in  1  1 = write (sw), 0 = read.
- `if_lb`  in  1  1 = load byte (sign-extended); ignored when `read_write`=1.
- `address`  in  10  byte address: [9:6] tag, [5:4] index, [3:2] word, [1:0] byte.
- `write_data`  in  32  store word.
- `hit_miss`  out  1  1 = request completes this cycle; the CPU advances on the next edge.
- `Read_Data`  out  32  load result; valid while `hit_miss`=1 and `read_write`=0, otherwise 0.
- `mem_request`  out  1  memory transaction pending.
- `mem_read_write`  out  1  1 = block write (write-back), 0 = block read (allocate).
- `mem_address`  out  10  block-aligned address; [3:0] is always 0.
- `mem_write_data`  out  128  victim block; word 0 is in [31:0].
- `mem_read_data`  in  128  fill block; valid while `mem_ready`=1.
- `mem_ready`  in  1  one-cycle pulse completing the pending memory transaction.

## Operation
- **Per-line state:** `valid`, `dirty`, 4-bit tag, 128-bit data.
- **Hit:** state is COMPARE, `valid[idx]`=1 and `tag[idx]`==`address[9:6]`.
- **Read hit:**
  - Word read: `Read_Data` = the selected word.
  - Load byte: `Read_Data` = {24{b[7]}, b}, where b is the byte at `address[1:0]` (little-endian: byte 0 = bits [7:0]).
- **Write hit:** on the edge where `hit_miss`=1, the word is written and `dirty` is set. A write is a full word; `if_lb` is ignored.
- **FSM states:** COMPARE, WRITE_BACK, ALLOCATE.
- **COMPARE:**
  - Hit: stay in COMPARE.
  - Miss with the victim valid and dirty: go to WRITE_BACK.
  - Any other miss: go to ALLOCATE.
  - On leaving COMPARE, latch the miss tag and index.
- **WRITE_BACK:**
  - Drive `mem_request`=1, `mem_read_write`=1, `mem_address`={victim tag, idx, 4'b0} and `mem_write_data`=victim data.
  - On `mem_ready`=1, go to ALLOCATE.
- **ALLOCATE:**
  - Drive `mem_request`=1, `mem_read_write`=0, `mem_address`={latched tag, idx, 4'b0}.
  - On `mem_ready`=1, load the line from `mem_read_data`, set `tag`, set `valid`=1, clear `dirty`, and go to COMPARE.
  - The retried request then hits, and a write hit sets `dirty` again.
- `hit_miss` is 0 in WRITE_BACK and ALLOCATE.
- In COMPARE, `mem_request`=0 and the other `mem_*` outputs are 0.

## Timing
- **Reset:**
  - Clears all `valid` and `dirty` bits and sets the state to COMPARE.
  - Leaves `hit_miss`=0, `Read_Data`=0, `mem_request`=0, `mem_read_write`=0, `mem_address`=0 and `mem_write_data`=0 from the first edge.
  - Data and tag arrays need no reset.
- **Reset mid-miss:** the memory transaction is abandoned, `mem_request` drops after the reset edge, and the line is not filled.
- **Hit latency:** 0 cycles. `hit_miss` and `Read_Data` are combinational from the request and the arrays.
- **Miss latency:** clean miss = 1 memory transaction + 1 cycle. Dirty miss = 2 memory transactions + 1 cycle.
- **Request stability:** the CPU holds its request stable while `hit_miss`=0. The block uses the latched tag and index during a miss.
- **Memory handshake:**
  - `mem_request` and the `mem_*` fields are registered and held constant until the edge that samples `mem_ready`=1.
  - `mem_ready` while `mem_request`=0 is ignored.
  - `mem_ready` may arrive in the first cycle that `mem_request` is high.
- **Back-to-back hits** complete one per cycle.
- **Same-line write then read:** a write hit followed by a read hit to the same word returns the new data.

## Test plan
- **Write miss, clean empty line, then read back:**
  - Stimulus: sw 0x3AB to 0b0110101000.
  - Required: one ALLOCATE read of block 0b0110100000 and no write-back; `hit_miss`=1 follows; a later read returns 0x000003AB.
- **Write hit, then read hit, same address:**
  - Stimulus: sw 0x3AC to 0b0110101000, then lw from the same address.
  - Required: no `mem_request`; `hit_miss`=1 in the same cycle for both; the read returns 0x3AC.
- **Dirty conflict miss:**
  - Stimulus: line 2 is dirty with tag 0110; read 0b0100101000.
  - Required: a WRITE_BACK to 0b0110100000 with word 2 = 0x3AC, then an ALLOCATE of 0b0100100000.
  - Follow-up: re-reading 0b0110101000 returns 0x3AC from memory.
- **Load byte, sign extension:**
  - Stimulus: word holds 0x000003AD; lb at offset 1.
  - Required: 0x00000003.
  - Stimulus: the same word with offset 0 holding 0x80; lb at offset 0.
  - Required: 0xFFFFFF80.
- **Reset mid-miss:**
  - Stimulus: assert `reset_n`=0 during ALLOCATE, before `mem_ready`.
  - Required: `mem_request`=0 after the edge; all lines invalid; the next access to that line misses.
- **Handshake stalls:**
  - Stimulus: `mem_ready` delayed 5 cycles in each transaction.
  - Required: `mem_*` outputs stable throughout; `hit_miss`=0 throughout; no double fill.
